se_sram_srw_32_master: RTL

//  Initiator for the single-port se_sram_srw_*x32_we8 SRAM interface (unregistered read data).

---
 rtl/se_sram_srw_32_master_if.sv | 51 +++++
 rtl/se_sram_srw_32_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/se_sram_srw_32_master_if.sv
// Request/response and SRAM-port bundle for the SRAM initiator.
// Latency: none (wires only).
// Backpressure: req_ready/resp_ready carry flow control; the SRAM side has none.
//
// Ports (signals):
//   req_*   : valid/ready request channel (read_not_write, address, byte_enable, write_data)
//   resp_*  : valid/ready response channel (read data at FIFO head)
//   sram_*  : single-port SRAM control; sram_data_in is the SRAM's unregistered data_out
// Modports: master = the initiator's view, slave = the surrounding environment's view.
interface se_sram_srw_32_master_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_read_not_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [BE_W-1:0]       req_byte_enable;
  logic [DATA_WIDTH-1:0] req_write_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  logic                  sram_select;
  logic                  sram_read_not_write;
  logic [ADDR_WIDTH-1:0] sram_address;
  logic [BE_W-1:0]       sram_write_enable;
  logic [DATA_WIDTH-1:0] sram_write_data;
  logic [DATA_WIDTH-1:0] sram_data_in;

  modport master (
    input  req_valid, req_read_not_write, req_address, req_byte_enable, req_write_data,
    output req_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output sram_select, sram_read_not_write, sram_address, sram_write_enable, sram_write_data,
    input  sram_data_in
  );

  modport slave (
    output req_valid, req_read_not_write, req_address, req_byte_enable, req_write_data,
    input  req_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  sram_select, sram_read_not_write, sram_address, sram_write_enable, sram_write_data,
    output sram_data_in
  );
endinterface

// File: rtl/se_sram_srw_32_master.sv
// Initiator for a single-port SRAM with unregistered read data; response FIFO on the read path.
// Latency: read accepted at edge N, data captured at edge N+1, resp_valid high from N+1.
// Backpressure: req_ready drops when FIFO entries plus in-flight reads would exceed RESP_DEPTH.
//
// Ports:
//   sram_clock         : rising-edge clock
//   reset              : asynchronous, active-high
//   sram_clock__enable : global clock enable; low holds every register
//   bus (master)       : request channel, response channel and SRAM port
// Optional feature macro: SE_SRAM_MASTER_WRITE_RESP_EN -- when defined each accepted write
// returns one response with data 0 through the same pipeline as reads.

// Small generic FIFO: count-based full/empty, pointers wrap modulo DEPTH.
// Latency: write visible at head the edge after push.
// Backpressure: none internally; the caller guarantees no push when full.
module se_sram_srw_32_master_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_rdy_i,
  output logic             rd_vld_o,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_fire  = rd_rdy_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_vld_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_fire)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_vld_i, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: nothing reads an entry before it has been written.
  always_ff @(posedge clk_i) begin
    if (en_i && wr_vld_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;
endmodule

module se_sram_srw_32_master #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic                   sram_clock,
  input  logic                   reset,
  input  logic                   sram_clock__enable,
  se_sram_srw_32_master_if.master bus
);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic                  read_pending_q, read_pending_d;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  pop;
  logic                  req_ready;
  logic                  accept;
  logic                  rsp_accept;
  logic [DATA_WIDTH-1:0] push_dat;
`ifdef SE_SRAM_MASTER_WRITE_RESP_EN
  // Remembers whether the in-flight response belongs to a write (data forced to 0).
  logic                  pending_wr_q, pending_wr_d;
`endif

  always_comb begin
    pop = bus.resp_valid && bus.resp_ready;
    // Credit: entries held plus the one being fetched, less the one leaving this cycle.
    occ = (CW+1)'(count) + (CW+1)'(read_pending_q) - (CW+1)'(pop);
    req_ready = sram_clock__enable && (occ < (CW+1)'(RESP_DEPTH));
    accept    = bus.req_valid && req_ready;
`ifdef SE_SRAM_MASTER_WRITE_RESP_EN
    rsp_accept   = accept;
    pending_wr_d = accept && !bus.req_read_not_write;
    push_dat     = pending_wr_q ? '0 : bus.sram_data_in;
`else
    rsp_accept   = accept && bus.req_read_not_write;
    push_dat     = bus.sram_data_in;
`endif
    read_pending_d = rsp_accept;
  end

  // While disabled the pending flag is held; the SRAM keeps data_out stable, so the
  // capture simply happens at the next enabled edge.
  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      read_pending_q <= 1'b0;
`ifdef SE_SRAM_MASTER_WRITE_RESP_EN
      pending_wr_q   <= 1'b0;
`endif
    end else if (sram_clock__enable) begin
      read_pending_q <= read_pending_d;
`ifdef SE_SRAM_MASTER_WRITE_RESP_EN
      pending_wr_q   <= pending_wr_d;
`endif
    end
  end

  se_sram_srw_32_master_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk_i    (sram_clock),
    .rst_i    (reset),
    .en_i     (sram_clock__enable),
    .wr_vld_i (read_pending_q),
    .wr_dat_i (push_dat),
    .rd_rdy_i (bus.resp_ready),
    .rd_vld_o (bus.resp_valid),
    .rd_dat_o (bus.resp_data),
    .count_o  (count)
  );

  // SRAM port is a direct combinational view of the accepted request.
  assign bus.req_ready           = req_ready;
  assign bus.sram_select         = accept;
  assign bus.sram_read_not_write = bus.req_read_not_write;
  assign bus.sram_address        = bus.req_address;
  assign bus.sram_write_enable   = bus.req_read_not_write ? '0 : bus.req_byte_enable;
  assign bus.sram_write_data     = bus.req_write_data;
endmodule
